reaction_timer_multi: RTL

- Multi-player, parametrised reaction-time tester; successor to the single-player fixed-width tester.
- On start it loads a switch-selected delay, counts it down, lights the go LED, then times each player's stop input independently.
- Adds false-start detection, timeout/saturation, winner selection and a done strobe.
- Sits between the switch/button debouncers and the seven-segment/LED display logic. Timing advances on a prescaled tick enable, not a derived clock.

---
 rtl/reaction_timer_multi.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/reaction_timer_multi.sv
// Multi-player reaction timer: switch-selected arm delay, per-player stop capture,
// false-start/timeout detection and winner pick. Optional best-time tracking: REACTION_BEST_TIME_EN.
module reaction_timer_multi #(
  parameter int N_PLAYERS = 2,
  parameter int DELAY_W   = 10,
  parameter int TIME_W    = 8,
  parameter int IDX_W     = 3
) (
  input  logic                          iClk,
  input  logic                          iRst,
  input  logic                          iTick,
  input  logic                          iStart,
  input  logic [DELAY_W-1:0]            iDelay,
  input  logic [N_PLAYERS-1:0]          iStop,
  output logic                          oLed,
  output logic                          oBusy,
  output logic                          oDone,
  output logic [N_PLAYERS*TIME_W-1:0]   oTime,
  output logic [N_PLAYERS-1:0]          oFoul,
  output logic                          oTimeout,
  output logic [IDX_W-1:0]              oWinner,
`ifdef REACTION_BEST_TIME_EN
  output logic                          oWinValid,
  output logic [TIME_W-1:0]             oBest,
  output logic                          oNewBest
`else
  output logic                          oWinValid
`endif
);

  // state | meaning
  // IDLE  | waiting for first start
  // ARM   | delay countdown, early presses are fouls
  // RUN   | go LED lit, timing each player
  // DONE  | results held until next start
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [TIME_W-1:0] MAX_TIME = '1;

  logic [1:0]                        state_q, state_d;
  logic [DELAY_W-1:0]                delay_q, delay_d;
  logic [TIME_W-1:0]                 cnt_q, cnt_d;
  logic [N_PLAYERS-1:0]              stopped_q, stopped_d;
  logic [N_PLAYERS-1:0]              hit_q, hit_d;
  logic [N_PLAYERS-1:0]              foul_q, foul_d;
  logic [N_PLAYERS*TIME_W-1:0]       time_q, time_d;
  logic                              timeout_q, timeout_d;
  logic                              done_q, done_d;
  logic [IDX_W-1:0]                  winner_q, winner_d;
  logic                              win_valid_q, win_valid_d;
  logic [N_PLAYERS-1:0]              press;
  logic                              found;
  logic [TIME_W-1:0]                 best_t;
  logic [IDX_W-1:0]                  win_idx;
`ifdef REACTION_BEST_TIME_EN
  logic [TIME_W-1:0]                 best_q, best_d;
  logic                              newbest_q, newbest_d;
`endif

  always_comb begin
    state_d     = state_q;
    delay_d     = delay_q;
    cnt_d       = cnt_q;
    stopped_d   = stopped_q;
    hit_d       = hit_q;
    foul_d      = foul_q;
    time_d      = time_q;
    timeout_d   = timeout_q;
    done_d      = 1'b0;
    winner_d    = winner_q;
    win_valid_d = win_valid_q;
    press       = '0;
    found       = 1'b0;
    best_t      = '1;
    win_idx     = '0;
`ifdef REACTION_BEST_TIME_EN
    best_d      = best_q;
    newbest_d   = 1'b0;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (iStart) begin
          state_d     = S_ARM;
          delay_d     = iDelay;
          cnt_d       = '0;
          stopped_d   = '0;
          hit_d       = '0;
          foul_d      = '0;
          time_d      = '0;
          timeout_d   = 1'b0;
          winner_d    = '0;
          win_valid_d = 1'b0;
        end
      end
      S_ARM: begin
        foul_d    = foul_q | iStop;
        stopped_d = stopped_q | iStop;
        if (&stopped_d) begin
          state_d = S_DONE;
        end else if (delay_q == '0) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else if (iTick) begin
          delay_d = delay_q - 1'b1;
        end
      end
      S_RUN: begin
        // a stop held over from ARM is already in stopped_q, so it cannot capture here
        press     = iStop & ~stopped_q;
        hit_d     = hit_q | press;
        stopped_d = stopped_q | press;
        for (int i = 0; i < N_PLAYERS; i++) begin
          if (press[i]) time_d[i*TIME_W +: TIME_W] = cnt_q;
        end
        if (iTick && cnt_q == MAX_TIME) begin
          for (int i = 0; i < N_PLAYERS; i++) begin
            if (!stopped_d[i]) time_d[i*TIME_W +: TIME_W] = MAX_TIME;
          end
          stopped_d = '1;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          if (iTick) cnt_d = cnt_q + 1'b1;
          if (&stopped_d) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // winner is resolved from the values being registered on DONE entry
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (hit_d[i] && (!found || time_d[i*TIME_W +: TIME_W] < best_t)) begin
        found   = 1'b1;
        best_t  = time_d[i*TIME_W +: TIME_W];
        win_idx = IDX_W'(i);
      end
    end

    if (state_d == S_DONE && state_q != S_DONE) begin
      done_d      = 1'b1;
      winner_d    = found ? win_idx : '0;
      win_valid_d = found;
`ifdef REACTION_BEST_TIME_EN
      if (found && best_t < best_q) begin
        best_d    = best_t;
        newbest_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q     <= S_IDLE;
      delay_q     <= '0;
      cnt_q       <= '0;
      stopped_q   <= '0;
      hit_q       <= '0;
      foul_q      <= '0;
      time_q      <= '0;
      timeout_q   <= 1'b0;
      done_q      <= 1'b0;
      winner_q    <= '0;
      win_valid_q <= 1'b0;
`ifdef REACTION_BEST_TIME_EN
      best_q      <= MAX_TIME;
      newbest_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      delay_q     <= delay_d;
      cnt_q       <= cnt_d;
      stopped_q   <= stopped_d;
      hit_q       <= hit_d;
      foul_q      <= foul_d;
      time_q      <= time_d;
      timeout_q   <= timeout_d;
      done_q      <= done_d;
      winner_q    <= winner_d;
      win_valid_q <= win_valid_d;
`ifdef REACTION_BEST_TIME_EN
      best_q      <= best_d;
      newbest_q   <= newbest_d;
`endif
    end
  end

  assign oLed      = (state_q == S_RUN);
  assign oBusy     = (state_q == S_ARM) || (state_q == S_RUN);
  assign oDone     = done_q;
  assign oTime     = time_q;
  assign oFoul     = foul_q;
  assign oTimeout  = timeout_q;
  assign oWinner   = winner_q;
  assign oWinValid = win_valid_q;
`ifdef REACTION_BEST_TIME_EN
  assign oBest     = best_q;
  assign oNewBest  = newbest_q;
`endif

endmodule
